// File: rtl/seq_detect_moore_param.sv
// Runtime-programmable Moore serial sequence detector with an N-bit pattern,
// overlap/non-overlap selection, bit-valid qualifier and saturating match counter.
module seq_detect_moore_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in,
    input  logic             en,
    input  logic             overlap,
    input  logic             load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic [N-1:0]     pattern
);

    localparam int             HW        = N - 1;
    localparam int             FW        = $clog2(N);
    localparam logic [FW-1:0]  FILL_FULL = FW'(N - 1);
    localparam logic [FW-1:0]  FILL_LAST = FW'(N - 2);

    typedef enum logic [1:0] {FILL, HUNT, MATCH} state_t;

    state_t        state;
    logic [HW-1:0] hist;
    logic [FW-1:0] fill;

    logic          accept;
    logic          evaluate;
    logic          hit;
    logic [N-1:0]  cand;

    assign accept   = en & ~load;
    assign cand     = {hist, in};
    // A full window is compared in HUNT, in MATCH when overlapping, and in FILL
    // only when a one-bit restart already saturated the fill (N == 2).
    assign evaluate = (state == HUNT)
                   || (state == MATCH && overlap)
                   || (state == FILL && fill == FILL_FULL);
    assign hit      = accept && evaluate && (cand == pattern);

    // NOTE: all state is updated with non-blocking assignments so every branch
    // sees the pre-edge values of hist/fill/state, matching the register model.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FILL;
            hist        <= '0;
            fill        <= '0;
            pattern     <= PATTERN;
            match_count <= '0;
            detected    <= 1'b0;
        end else begin
            detected <= hit;

            // Clear takes priority but a coincident match still counts once.
            if (cnt_clr)
                match_count <= hit ? CNT_W'(1) : '0;
            else if (hit && match_count != '1)
                match_count <= match_count + CNT_W'(1);

            if (load) begin
                pattern <= pat_in;
                hist    <= '0;
                fill    <= '0;
                state   <= FILL;
            end else if (hit) begin
                hist  <= cand[N-2:0];
                state <= MATCH;
            end else begin
                case (state)
                    FILL: begin
                        if (accept) begin
                            hist <= cand[N-2:0];
                            if (fill != FILL_FULL)
                                fill <= fill + FW'(1);
                            if (fill >= FILL_LAST)
                                state <= HUNT;
                        end
                    end
                    HUNT: begin
                        if (accept)
                            hist <= cand[N-2:0];
                    end
                    MATCH: begin
                        if (!accept) begin
                            if (overlap) begin
                                state <= HUNT;
                            end else begin
                                state <= FILL;
                                hist  <= '0;
                                fill  <= '0;
                            end
                        end else if (overlap) begin
                            hist  <= cand[N-2:0];
                            state <= HUNT;
                        end else begin
                            // Non-overlapping: this bit opens a fresh window.
                            hist  <= HW'(in);
                            fill  <= FW'(1);
                            state <= FILL;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Self-checking bench for seq_detect_moore_param: vector table, hand-written
// corner sequences and random stimulus against a window-based reference model.
module tb_seq_detect_moore_param;

    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int CW2 = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_bit = 1'b0;
    logic           en = 1'b0;
    logic           overlap = 1'b0;
    logic           load = 1'b0;
    logic           cnt_clr = 1'b0;
    logic [N-1:0]   pat_in = '0;

    logic           detected, detected2;
    logic [CW-1:0]  match_count;
    logic [CW2-1:0] match_count2;
    logic [N-1:0]   pattern, pattern2;

    always #5 clk = ~clk;

    seq_detect_moore_param #(.N(N), .PATTERN(4'b1101), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in(in_bit), .en(en), .overlap(overlap),
        .load(load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .detected(detected), .match_count(match_count), .pattern(pattern)
    );

    seq_detect_moore_param #(.N(N), .PATTERN(4'b1101), .CNT_W(CW2)) dut_w2 (
        .clk(clk), .reset_n(reset_n), .in(in_bit), .en(en), .overlap(overlap),
        .load(load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .detected(detected2), .match_count(match_count2), .pattern(pattern2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the accepted bits since the last restart, kept as a queue.
    bit           m_win[$];
    logic [N-1:0] m_pat;
    bit           m_match;
    int           m_cnt, m_cnt2;

    task automatic model_reset();
        m_win.delete();
        m_pat   = 4'b1101;
        m_match = 1'b0;
        m_cnt   = 0;
        m_cnt2  = 0;
    endtask

    task automatic model_edge();
        bit hit = 1'b0;
        logic [N-1:0] v;
        if (load) begin
            m_pat = pat_in;
            m_win.delete();
        end else begin
            if (m_match && !overlap) m_win.delete();
            if (en) begin
                m_win.push_back(in_bit);
                if (m_win.size() > N) void'(m_win.pop_front());
                if (m_win.size() == N) begin
                    v = '0;
                    for (int i = 0; i < N; i++) v = {v[N-2:0], m_win[i]};
                    hit = (v == m_pat);
                end
            end
        end
        m_match = hit;
        if (cnt_clr) begin
            m_cnt  = hit ? 1 : 0;
            m_cnt2 = hit ? 1 : 0;
        end else if (hit) begin
            if (m_cnt  < (1 << CW)  - 1) m_cnt++;
            if (m_cnt2 < (1 << CW2) - 1) m_cnt2++;
        end
    endtask

    // One clock: drive, let the edge happen, update the model, compare 1 ns later.
    task automatic cyc(input logic i, input logic e, input logic o,
                       input logic l = 1'b0, input logic [N-1:0] p = '0,
                       input logic c = 1'b0);
        in_bit = i; en = e; overlap = o; load = l; pat_in = p; cnt_clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check("detected",    detected,     m_match);
        check("detected_w2", detected2,    m_match);
        check("match_count", match_count,  m_cnt);
        check("count_w2",    match_count2, m_cnt2);
        check("pattern",     pattern,      m_pat);
        check("pattern_w2",  pattern2,     m_pat);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        in_bit = 1'b0; en = 1'b0; load = 1'b0; cnt_clr = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_detected", detected,    0);
        check("rst_count",    match_count, 0);
        check("rst_pattern",  pattern,     4'b1101);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic in_b;
        logic en_b;
        logic ov;
        logic exp_det;
        int   exp_cnt;
    } vec_t;

    vec_t tbl[14];
    int   highs;

    initial begin
        // 1101101 with overlap, then the same stream without overlap.
        tbl[0]  = '{1, 1, 1, 0, 0};  tbl[1]  = '{1, 1, 1, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0};  tbl[3]  = '{1, 1, 1, 1, 1};
        tbl[4]  = '{1, 1, 1, 0, 1};  tbl[5]  = '{0, 1, 1, 0, 1};
        tbl[6]  = '{1, 1, 1, 1, 2};
        tbl[7]  = '{1, 1, 0, 0, 0};  tbl[8]  = '{1, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0};  tbl[10] = '{1, 1, 0, 1, 1};
        tbl[11] = '{1, 1, 0, 0, 1};  tbl[12] = '{0, 1, 0, 0, 1};
        tbl[13] = '{1, 1, 0, 0, 1};

        model_reset();
        #12;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            if (i == 7) do_reset();
            cyc(tbl[i].in_b, tbl[i].en_b, tbl[i].ov);
            check($sformatf("tbl%0d_det", i), detected,    tbl[i].exp_det);
            check($sformatf("tbl%0d_cnt", i), match_count, tbl[i].exp_cnt);
        end

        // Pattern 1111, six ones: three consecutive detects with overlap, one without.
        for (int ov = 1; ov >= 0; ov--) begin
            do_reset();
            cyc(1'b0, 1'b1, ov[0], 1'b1, 4'b1111);
            highs = 0;
            for (int k = 0; k < 6; k++) begin
                cyc(1'b1, 1'b1, ov[0]);
                highs += int'(detected);
            end
            check(ov ? "ones_ovl_highs" : "ones_novl_highs", highs, ov ? 3 : 1);
            check(ov ? "ones_ovl_cnt" : "ones_novl_cnt", match_count, ov ? 3 : 1);
        end

        // 1101 with two idle cycles between bits while `in` toggles.
        do_reset();
        highs = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(k != 2, 1'b1, 1'b1);
            highs += int'(detected);
            for (int g = 0; g < 2; g++) begin
                cyc(g[0], 1'b0, 1'b1);
                highs += int'(detected);
            end
        end
        check("gap_highs", highs, 1);
        check("gap_cnt", match_count, 1);

        // Load 0110 mid-stream with en=1; the loading bit must be ignored.
        do_reset();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check("load_nodet_yet", detected, 0);
        cyc(1'b0, 1'b1, 1'b1);
        check("load_det", detected, 1);
        check("load_pattern", pattern, 4'b0110);
        do_reset();

        // Five overlapping matches saturate the 2-bit counter at 3.
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1);
        end
        check("sat_cnt_w2", match_count2, 3);
        check("sat_cnt_w8", match_count, 5);
        // cnt_clr on the same edge as a match leaves a count of one.
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        check("clr_hit_det", detected, 1);
        check("clr_hit_w2", match_count2, 1);
        check("clr_hit_w8", match_count, 1);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] rp;
            rp = N'($urandom);
            cyc(1'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(7, 0) != 0),
                ($urandom_range(63, 0) == 0), rp, ($urandom_range(99, 0) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
